// File: rtl/mux_key_pkg.sv
// Shared types and pair-slicing helpers for the mux_key lookup multiplexer.
package mux_key_pkg;

    typedef struct packed {
        logic hit;
        logic multi_hit;
    } status_t;

    function automatic int pair_len(input int key_len, input int data_len);
        return key_len + data_len;
    endfunction

    // Pair idx starts at idx*pair_len; data sits in the low bits, key above it.
    function automatic int data_lsb(input int idx, input int key_len, input int data_len);
        return idx * pair_len(key_len, data_len);
    endfunction

    function automatic int key_lsb(input int idx, input int key_len, input int data_len);
        return idx * pair_len(key_len, data_len) + data_len;
    endfunction

endpackage

// File: rtl/mux_key_match.sv
// Single-entry comparator: flags an exact key match and gates the entry data with it.
module mux_key_match #(
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
) (
    input  logic [KEY_LEN-1:0]  key,
    input  logic [KEY_LEN-1:0]  entry_key,
    input  logic [DATA_LEN-1:0] entry_data,
    output logic                match,
    output logic [DATA_LEN-1:0] data_gated
);

    assign match      = (entry_key == key);
    assign data_gated = entry_data & {DATA_LEN{match}};

endmodule

// File: rtl/mux_key.sv
// Key-lookup multiplexer with combinational result and registered out/hit/multi-hit copy.
// Optional build macro MUX_KEY_DEFAULT_EN adds default_out, driven onto out on a miss.
module mux_key
    import mux_key_pkg::*;
#(
    parameter int NR_KEY   = 2,
    parameter int KEY_LEN  = 1,
    parameter int DATA_LEN = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [KEY_LEN-1:0]                     key,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]   lut,
`ifdef MUX_KEY_DEFAULT_EN
    input  logic [DATA_LEN-1:0]                    default_out,
`endif
    output logic [DATA_LEN-1:0]                    out,
    output logic                                   hit,
    output logic [DATA_LEN-1:0]                    out_q,
    output logic                                   hit_q,
    output logic                                   multi_hit_q
);

    logic [NR_KEY-1:0]   match_vec;
    logic [DATA_LEN-1:0] gated_data [NR_KEY];
    logic [DATA_LEN-1:0] or_data;
    logic                multi_hit;

    logic [DATA_LEN-1:0] out_reg;
    status_t             status_reg;
    status_t             status_next;

    generate
        for (genvar gi = 0; gi < NR_KEY; gi++) begin : g_entry
            mux_key_match #(
                .KEY_LEN  (KEY_LEN),
                .DATA_LEN (DATA_LEN)
            ) u_match (
                .key        (key),
                .entry_key  (lut[key_lsb(gi, KEY_LEN, DATA_LEN) +: KEY_LEN]),
                .entry_data (lut[data_lsb(gi, KEY_LEN, DATA_LEN) +: DATA_LEN]),
                .match      (match_vec[gi]),
                .data_gated (gated_data[gi])
            );
        end
    endgenerate

    // multi_hit sets once a match is seen while an earlier entry already matched.
    always_comb begin
        logic seen_one;
        or_data   = '0;
        multi_hit = 1'b0;
        seen_one  = 1'b0;
        for (int i = 0; i < NR_KEY; i++) begin
            multi_hit = multi_hit | (seen_one & match_vec[i]);
            seen_one  = seen_one | match_vec[i];
            or_data   = or_data | gated_data[i];
        end
    end

    assign hit = |match_vec;

`ifdef MUX_KEY_DEFAULT_EN
    assign out = hit ? or_data : default_out;
`else
    assign out = or_data;
`endif

    always_comb begin
        status_next           = '0;
        status_next.hit       = hit;
        status_next.multi_hit = multi_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg    <= '0;
            status_reg <= '0;
        end else begin
            out_reg    <= out;
            status_reg <= status_next;
        end
    end

    assign out_q       = out_reg;
    assign hit_q       = status_reg.hit;
    assign multi_hit_q = status_reg.multi_hit;

endmodule

// File: tb/tb_mux_key.sv
// Directed self-checking bench for mux_key across several table geometries.
module tb_mux_key;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Miss values depend on whether the default-output build is selected.
`ifdef MUX_KEY_DEFAULT_EN
    localparam logic [15:0] MISS_B = 16'hFFFF;
    localparam logic [7:0]  MISS_C = 8'h81;
    localparam logic [3:0]  MISS_E = 4'h9;
`else
    localparam logic [15:0] MISS_B = 16'h0000;
    localparam logic [7:0]  MISS_C = 8'h00;
    localparam logic [3:0]  MISS_E = 4'h0;
`endif

    // A: byte-lane select
    logic [1:0]  key_a;
    logic [39:0] lut_a;
    logic [7:0]  def_a = 8'h3C;
    logic [7:0]  out_a, out_q_a;
    logic        hit_a, hit_q_a, multi_q_a;
    // B: miss case
    logic [1:0]  key_b;
    logic [53:0] lut_b;
    logic [15:0] def_b = 16'hFFFF;
    logic [15:0] out_b, out_q_b;
    logic        hit_b, hit_q_b, multi_q_b;
    // C: duplicate keys
    logic [2:0]  key_c;
    logic [32:0] lut_c;
    logic [7:0]  def_c = 8'h81;
    logic [7:0]  out_c, out_q_c;
    logic        hit_c, hit_q_c, multi_q_c;
    // D: wide data
    logic [2:0]   key_d;
    logic [174:0] lut_d;
    logic [31:0]  def_d = 32'hCAFEF00D;
    logic [31:0]  out_d, out_q_d;
    logic         hit_d, hit_q_d, multi_q_d;
    // E: single entry
    logic [1:0] key_e;
    logic [5:0] lut_e;
    logic [3:0] def_e = 4'h9;
    logic [3:0] out_e, out_q_e;
    logic       hit_e, hit_q_e, multi_q_e;

    mux_key #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(8)) u_a (
        .clk(clk), .rst(rst), .key(key_a), .lut(lut_a),
`ifdef MUX_KEY_DEFAULT_EN
        .default_out(def_a),
`endif
        .out(out_a), .hit(hit_a), .out_q(out_q_a), .hit_q(hit_q_a), .multi_hit_q(multi_q_a));

    mux_key #(.NR_KEY(3), .KEY_LEN(2), .DATA_LEN(16)) u_b (
        .clk(clk), .rst(rst), .key(key_b), .lut(lut_b),
`ifdef MUX_KEY_DEFAULT_EN
        .default_out(def_b),
`endif
        .out(out_b), .hit(hit_b), .out_q(out_q_b), .hit_q(hit_q_b), .multi_hit_q(multi_q_b));

    mux_key #(.NR_KEY(3), .KEY_LEN(3), .DATA_LEN(8)) u_c (
        .clk(clk), .rst(rst), .key(key_c), .lut(lut_c),
`ifdef MUX_KEY_DEFAULT_EN
        .default_out(def_c),
`endif
        .out(out_c), .hit(hit_c), .out_q(out_q_c), .hit_q(hit_q_c), .multi_hit_q(multi_q_c));

    mux_key #(.NR_KEY(5), .KEY_LEN(3), .DATA_LEN(32)) u_d (
        .clk(clk), .rst(rst), .key(key_d), .lut(lut_d),
`ifdef MUX_KEY_DEFAULT_EN
        .default_out(def_d),
`endif
        .out(out_d), .hit(hit_d), .out_q(out_q_d), .hit_q(hit_q_d), .multi_hit_q(multi_q_d));

    mux_key #(.NR_KEY(1), .KEY_LEN(2), .DATA_LEN(4)) u_e (
        .clk(clk), .rst(rst), .key(key_e), .lut(lut_e),
`ifdef MUX_KEY_DEFAULT_EN
        .default_out(def_e),
`endif
        .out(out_e), .hit(hit_e), .out_q(out_q_e), .hit_q(hit_q_e), .multi_hit_q(multi_q_e));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [7:0] exp_a [4];

    initial begin
        exp_a[0] = 8'hAA; exp_a[1] = 8'hBB; exp_a[2] = 8'hCC; exp_a[3] = 8'hDD;
        lut_a = {2'b00, 8'hAA, 2'b01, 8'hBB, 2'b10, 8'hCC, 2'b11, 8'hDD};
        lut_b = {2'b00, 16'h1234, 2'b01, 16'h5678, 2'b10, 16'h9ABC};
        lut_c = {3'b010, 8'h0F, 3'b010, 8'hF0, 3'b100, 8'h55};
        lut_d = {3'b000, 32'h11111111, 3'b001, 32'h22222222, 3'b010, 32'hDEADBEEF,
                 3'b011, 32'h44444444, 3'b100, 32'h55555555};
        lut_e = {2'b10, 4'h6};
        key_a = 2'b00; key_b = 2'b00; key_c = 3'b000; key_d = 3'b000; key_e = 2'b00;

        // reset state; combinational path still live while rst is high
        @(posedge clk); #1;
        chk("rst_out_q_a", 64'(out_q_a), 64'h0);
        chk("rst_hit_q_a", 64'(hit_q_a), 64'h0);
        chk("rst_multi_q_c", 64'(multi_q_c), 64'h0);
        chk("rst_out_q_d", 64'(out_q_d), 64'h0);
        chk("rst_out_a_live", 64'(out_a), 64'hAA);
        chk("rst_hit_a_live", 64'(hit_a), 64'h1);
        @(negedge clk); rst = 1'b0;

        // A: sweep all four lanes
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); key_a = 2'(i); #1;
            chk($sformatf("a_out_k%0d", i), 64'(out_a), 64'(exp_a[i]));
            chk($sformatf("a_hit_k%0d", i), 64'(hit_a), 64'h1);
            @(posedge clk); #1;
            chk($sformatf("a_out_q_k%0d", i), 64'(out_q_a), 64'(exp_a[i]));
            chk($sformatf("a_hit_q_k%0d", i), 64'(hit_q_a), 64'h1);
            chk($sformatf("a_multi_q_k%0d", i), 64'(multi_q_a), 64'h0);
        end

        // A: table edit propagates combinationally
        @(negedge clk); key_a = 2'b00; lut_a[37:30] = 8'h5A; #1;
        chk("a_lut_edit", 64'(out_a), 64'h5A);
        @(negedge clk); lut_a[37:30] = 8'hAA; #1;
        chk("a_lut_restore", 64'(out_a), 64'hAA);

        // B: hit then miss
        @(negedge clk); key_b = 2'b01; #1;
        chk("b_out_hit", 64'(out_b), 64'h5678);
        @(negedge clk); key_b = 2'b11; #1;
        chk("b_out_miss", 64'(out_b), 64'(MISS_B));
        chk("b_hit_miss", 64'(hit_b), 64'h0);
        @(posedge clk); #1;
        chk("b_hit_q_miss", 64'(hit_q_b), 64'h0);
        chk("b_out_q_miss", 64'(out_q_b), 64'(MISS_B));
        chk("b_multi_q_miss", 64'(multi_q_b), 64'h0);

        // C: duplicate keys OR together
        @(negedge clk); key_c = 3'b010; #1;
        chk("c_out_dup", 64'(out_c), 64'hFF);
        chk("c_hit_dup", 64'(hit_c), 64'h1);
        @(posedge clk); #1;
        chk("c_multi_q_dup", 64'(multi_q_c), 64'h1);
        chk("c_out_q_dup", 64'(out_q_c), 64'hFF);
        @(negedge clk); key_c = 3'b100; #1;
        chk("c_out_single", 64'(out_c), 64'h55);
        @(posedge clk); #1;
        chk("c_multi_q_single", 64'(multi_q_c), 64'h0);
        chk("c_hit_q_single", 64'(hit_q_c), 64'h1);
        @(negedge clk); key_c = 3'b111; #1;
        chk("c_out_miss", 64'(out_c), 64'(MISS_C));

        // D: wide data, neighbours must not bleed in
        @(negedge clk); key_d = 3'b000; #1;
        chk("d_out_top", 64'(out_d), 64'h11111111);
        @(negedge clk); key_d = 3'b100; #1;
        chk("d_out_bottom", 64'(out_d), 64'h55555555);
        @(negedge clk); key_d = 3'b010; #1;
        chk("d_out_mid", 64'(out_d), 64'hDEADBEEF);
        chk("d_hit_mid", 64'(hit_d), 64'h1);
        @(posedge clk); #1;
        chk("d_out_q_mid", 64'(out_q_d), 64'hDEADBEEF);
        chk("d_hit_q_mid", 64'(hit_q_d), 64'h1);
        chk("d_multi_q_mid", 64'(multi_q_d), 64'h0);

        // D: asynchronous reset mid-cycle
        #1; rst = 1'b1; #1;
        chk("d_async_out_q", 64'(out_q_d), 64'h0);
        chk("d_async_hit_q", 64'(hit_q_d), 64'h0);
        chk("d_async_out_live", 64'(out_d), 64'hDEADBEEF);
        @(negedge clk); rst = 1'b0; #1;
        chk("d_post_rst_hold", 64'(out_q_d), 64'h0);
        @(posedge clk); #1;
        chk("d_reload", 64'(out_q_d), 64'hDEADBEEF);

        // E: single-entry table
        @(negedge clk); key_e = 2'b10; #1;
        chk("e_out_hit", 64'(out_e), 64'h6);
        chk("e_hit", 64'(hit_e), 64'h1);
        @(posedge clk); #1;
        chk("e_out_q_hit", 64'(out_q_e), 64'h6);
        chk("e_hit_q", 64'(hit_q_e), 64'h1);
        chk("e_multi_q", 64'(multi_q_e), 64'h0);
        @(negedge clk); key_e = 2'b01; #1;
        chk("e_out_miss", 64'(out_e), 64'(MISS_E));

        // A: back-to-back alternation, out_q lags out by one cycle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); key_a = (i % 2 == 0) ? 2'b00 : 2'b11; #1;
            chk($sformatf("b2b_out_%0d", i), 64'(out_a), (i % 2 == 0) ? 64'hAA : 64'hDD);
            if (i > 0)
                chk($sformatf("b2b_lag_%0d", i), 64'(out_q_a), (i % 2 == 0) ? 64'hDD : 64'hAA);
            @(posedge clk); #1;
            chk($sformatf("b2b_out_q_%0d", i), 64'(out_q_a), (i % 2 == 0) ? 64'hAA : 64'hDD);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_key.md
Name: mux_key

Overview:
- Parameterised key-lookup multiplexer: compares an input key against a packed table of (key, data) pairs and outputs the data of the matching entry.
- Used throughout the datapath for opcode- and offset-driven selection, e.g. memory read/write lane selection by access size and address offset.
- Provides the combinational result plus a registered copy with hit/multi-hit status for timing-critical consumers.

Parameters:
- NR_KEY, 2, number of (key, data) pairs in the table; must be >= 1.
- KEY_LEN, 1, key width in bits; must be >= 1.
- DATA_LEN, 1, data width in bits; must be >= 1.

Ports:
- clk  input  1  clock; only the registered outputs use it.
- rst  input  1  asynchronous, active-high reset.
- key  input  KEY_LEN  lookup key.
- lut  input  NR_KEY*(KEY_LEN+DATA_LEN)  packed table; first-listed pair in the MSBs.
- out  output  DATA_LEN  combinational lookup result.
- hit  output  1  combinational; at least one entry matches.
- out_q  output  DATA_LEN  out registered on the clk rising edge.
- hit_q  output  1  hit registered.
- multi_hit_q  output  1  registered; two or more entries matched.

Behaviour:
- PAIR_LEN = KEY_LEN+DATA_LEN.
- Pair index j (0 = least significant) occupies lut[j*PAIR_LEN +: PAIR_LEN].
- Within each pair, the key is the upper KEY_LEN bits and the data is the lower DATA_LEN bits.
- Concatenation {k_a,d_a,k_b,d_b,...} therefore places the first-listed pair at the top.
- Match for entry j: key_j == key, exact bitwise equality. X/Z handling is not required.
- out is the bitwise OR of data_j over all matching entries.
  - A single match yields that entry's data exactly.
  - Duplicate keys OR their data together; this is legal and intended.
- Miss (no match): out = 0, hit = 0.
- out and hit are purely combinational. Zero-cycle latency from key and lut.
- Registered path, one-cycle latency:
  - On each clk rising edge: out_q <= out, hit_q <= hit, multi_hit_q <= (match count >= 2).
  - No enable; updates every cycle.
- Reset:
  - rst high asynchronously forces out_q = 0, hit_q = 0, multi_hit_q = 0, regardless of clk.
  - Registers hold 0 while rst is high.
  - The first capture occurs on the first rising edge after rst deasserts.
- Reset does not affect out or hit; they track inputs during reset.
- NR_KEY = 1 is legal: out = data_0 when key matches, else 0.
- Table contents may change every cycle. out follows the table combinationally; out_q reflects the table value present at the capture edge.

Optional Feature:
- Macro MUX_KEY_DEFAULT_EN.
- When defined:
  - Adds input port default_out, DATA_LEN bits.
  - On a miss, out = default_out and out_q captures it.
  - hit remains 0 on a miss.
  - The reset value of out_q stays 0.
- When undefined: the port is absent and a miss yields 0.
- Matching behaviour is identical in both builds.

Decomposition:
- Shared package mux_key_pkg holds:
  - function pair_len(key_len, data_len);
  - localparam-style helpers for pair slicing offsets;
  - a typedef for the 2-bit status encoding {hit, multi_hit}.
- One sub-module is natural: mux_key_match, a single-entry comparator producing a match bit and gated data (data & {DATA_LEN{match}}). It is instantiated NR_KEY times via generate.
- The top level performs the OR-reduction, the match-count >= 2 detection, and the output registers.

Test Plan:
- Byte-lane select, NR_KEY=4, KEY_LEN=2, DATA_LEN=8, lut {00,AA, 01,BB, 10,CC, 11,DD}: sweep key 00..11 -> out AA,BB,CC,DD, hit=1. One cycle later -> out_q matches, multi_hit_q=0.
- Miss, NR_KEY=3, KEY_LEN=2, DATA_LEN=16, lut {00,1234, 01,5678, 10,9ABC}, key=11 -> out=0000, hit=0, hit_q=0 next cycle.
  - With MUX_KEY_DEFAULT_EN and default_out=FFFF -> out=FFFF, hit=0.
- Duplicate keys, KEY_LEN=3, DATA_LEN=8, lut {010,0F, 010,F0, 100,55}, key=010 -> out=FF, hit=1, multi_hit_q=1 after the edge. key=100 -> out=55, multi_hit_q=0.
- Wide data, NR_KEY=5, KEY_LEN=3, DATA_LEN=32, key=010 selecting 0xDEADBEEF -> out=DEADBEEF. Confirms MSB-first packing with no bit slip into adjacent pairs.
- Async reset: with out_q=DEADBEEF, assert rst mid-cycle with no clk edge -> out_q=0, hit_q=0 immediately, while out still shows DEADBEEF. Deassert rst -> out_q reloads on the next rising edge.
- Back-to-back changes: alternate key 00/11 every cycle on the first table -> out_q sequence AA,DD,AA,DD, lagging out by exactly one cycle.
